// File: rtl/axi_lite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_pkg                                                                |
// | Response codes shared by the AXI4-Lite master and slave.                    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package axi_lite_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_regfile                                                            |
// | NREG x DW registers, one sync write port, one sync read-before-write port.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module axi_lite_regfile #(
   parameter int DW   = 32,
   parameter int NREG = 8,
   parameter int IDXW = $clog2(NREG)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [IDXW-1:0]    wr_idx,
   input  logic [DW-1:0]      wr_data,
   input  logic               rd_en,
   input  logic [IDXW-1:0]    rd_idx,
   output logic [DW-1:0]      rd_data,
   output logic [NREG*DW-1:0] regs_flat
);
   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic [DW-1:0] rd_data_q;
   logic [DW-1:0] rd_data_d;

   // The read port samples regs_q, so a same-edge write is not visible yet.
   always_comb begin
      regs_d    = regs_q;
      rd_data_d = rd_data_q;
      if (wr_en) begin
         regs_d[wr_idx] = wr_data;
      end
      if (rd_en) begin
         rd_data_d = regs_q[rd_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q    <= '{default: '0};
         rd_data_q <= '0;
      end else begin
         regs_q    <= regs_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

   generate
      for (genvar i = 0; i < NREG; i++) begin : g_flat
         assign regs_flat[i*DW +: DW] = regs_q[i];
      end
   endgenerate
endmodule
`default_nettype wire

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lite_slave_regs                                                         |
// | AXI4-Lite slave exposing a decoded register file to user logic.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module axi_lite_slave_regs
   import axi_lite_pkg::*;
#(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int NREG = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     AWVALID,
   input  logic [AW-1:0]            AWADDR,
   output logic                     AWREADY,
   input  logic                     WVALID,
   input  logic [DW-1:0]            WDATA,
   output logic                     WREADY,
   output logic                     BVALID,
   output logic [1:0]               BRESP,
   input  logic                     BREADY,
   input  logic                     ARVALID,
   input  logic [AW-1:0]            ARADDR,
   output logic                     ARREADY,
   output logic                     RVALID,
   output logic [DW-1:0]            RDATA,
   output logic [1:0]               RRESP,
   input  logic                     RREADY,
   output logic [NREG*DW-1:0]       REG_OUT,
   output logic                     WR_PULSE,
   output logic [$clog2(NREG)-1:0]  WR_IDX
);
   localparam int IDXW     = $clog2(NREG);
   localparam int ADDR_LSB = $clog2(DW/8);
   localparam logic [IDXW:0] C_NREG = (IDXW+1)'(NREG);

   logic            aw_hold_q, aw_hold_d;
   logic            aw_ok_q, aw_ok_d;
   logic [IDXW-1:0] aw_idx_q, aw_idx_d;
   logic            w_hold_q, w_hold_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;
   logic            wr_pulse_q, wr_pulse_d;
   logic [IDXW-1:0] wr_idx_q, wr_idx_d;
   logic            rvalid_q, rvalid_d;
   logic [1:0]      rresp_q, rresp_d;

   logic [IDXW-1:0] w_aw_idx, w_ar_idx;
   logic            w_aw_ok, w_ar_ok;
   logic            w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [DW-1:0]   w_rf_rdata;
   logic            w_unused_addr_lsbs;

   // Byte-lane bits below the word stride carry no information.
   assign w_aw_idx = AWADDR[ADDR_LSB +: IDXW];
   assign w_ar_idx = ARADDR[ADDR_LSB +: IDXW];
   assign w_aw_ok  = ({1'b0, w_aw_idx} < C_NREG) && (AWADDR[AW-1:ADDR_LSB+IDXW] == '0);
   assign w_ar_ok  = ({1'b0, w_ar_idx} < C_NREG) && (ARADDR[AW-1:ADDR_LSB+IDXW] == '0);
   assign w_unused_addr_lsbs = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

   assign AWREADY  = ~aw_hold_q & ~bvalid_q;
   assign WREADY   = ~w_hold_q & ~bvalid_q;
   assign ARREADY  = ~rvalid_q;
   assign w_aw_hs  = AWVALID & AWREADY;
   assign w_w_hs   = WVALID & WREADY;
   assign w_ar_hs  = ARVALID & ARREADY;
   assign w_commit = aw_hold_q & w_hold_q;

   always_comb begin
      aw_hold_d  = aw_hold_q;
      aw_ok_d    = aw_ok_q;
      aw_idx_d   = aw_idx_q;
      w_hold_d   = w_hold_q;
      wdata_d    = wdata_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      wr_pulse_d = 1'b0;
      wr_idx_d   = wr_idx_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;

      if (w_aw_hs) begin
         aw_hold_d = 1'b1;
         aw_ok_d   = w_aw_ok;
         aw_idx_d  = w_aw_idx;
      end
      if (w_w_hs) begin
         w_hold_d = 1'b1;
         wdata_d  = WDATA;
      end

      // Holds cannot be re-armed while BVALID is up, so commit and B handshake never overlap.
      if (w_commit) begin
         aw_hold_d  = 1'b0;
         w_hold_d   = 1'b0;
         bvalid_d   = 1'b1;
         bresp_d    = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
         wr_pulse_d = aw_ok_q;
         if (aw_ok_q) begin
            wr_idx_d = aw_idx_q;
         end
      end else if (bvalid_q && BREADY) begin
         bvalid_d = 1'b0;
      end

      if (w_ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = w_ar_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         aw_hold_q  <= 1'b0;
         aw_ok_q    <= 1'b0;
         aw_idx_q   <= '0;
         w_hold_q   <= 1'b0;
         wdata_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= 1'b0;
         wr_idx_q   <= '0;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
      end else begin
         aw_hold_q  <= aw_hold_d;
         aw_ok_q    <= aw_ok_d;
         aw_idx_q   <= aw_idx_d;
         w_hold_q   <= w_hold_d;
         wdata_q    <= wdata_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         wr_pulse_q <= wr_pulse_d;
         wr_idx_q   <= wr_idx_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
      end
   end

   axi_lite_regfile #(
      .DW   (DW),
      .NREG (NREG),
      .IDXW (IDXW)
   ) u_regfile (
      .clk       (CLK),
      .rst       (RESET),
      .wr_en     (w_commit & aw_ok_q),
      .wr_idx    (aw_idx_q),
      .wr_data   (wdata_q),
      .rd_en     (w_ar_hs & w_ar_ok),
      .rd_idx    (w_ar_idx),
      .rd_data   (w_rf_rdata),
      .regs_flat (REG_OUT)
   );

   // Error reads leave the read port untouched, so the data is masked here.
   assign RDATA    = (rresp_q == RESP_OKAY) ? w_rf_rdata : '0;
   assign RRESP    = rresp_q;
   assign RVALID   = rvalid_q;
   assign BVALID   = bvalid_q;
   assign BRESP    = bresp_q;
   assign WR_PULSE = wr_pulse_q;
   assign WR_IDX   = wr_idx_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_lite_slave_regs                                                      |
// | Directed stimulus with queued expected B/R/WR_PULSE responses.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_axi_lite_slave_regs;
   import axi_lite_pkg::*;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
   logic [31:0]  AWADDR, WDATA, ARADDR;
   logic         AWREADY, WREADY, BVALID, ARREADY, RVALID, WR_PULSE;
   logic [1:0]   BRESP, RRESP;
   logic [31:0]  RDATA;
   logic [255:0] REG_OUT;
   logic [2:0]   WR_IDX;

   always #5 CLK = ~CLK;

   axi_lite_slave_regs #(.AW(32), .DW(32), .NREG(8)) dut (
      .CLK(CLK), .RESET(RESET),
      .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
      .WVALID(WVALID), .WDATA(WDATA), .WREADY(WREADY),
      .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
      .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
      .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
      .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE), .WR_IDX(WR_IDX)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   int          checks   = 0;
   int          failures = 0;
   int          b_seen   = 0;
   int          r_seen   = 0;
   logic [1:0]  b_q [$];
   r_exp_t      r_q [$];
   logic [2:0]  p_q [$];
   logic [255:0] snapshot;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Response monitor: pops the scoreboard whenever the DUT completes a response.
   always @(negedge CLK) begin
      if (RESET === 1'b0) begin
         if (BVALID && BREADY) begin
            if (b_q.size() == 0) check("b_unexpected", BVALID, 1'b0);
            else check("bresp", BRESP, b_q.pop_front());
            b_seen++;
         end
         if (RVALID && RREADY) begin
            if (r_q.size() == 0) check("r_unexpected", RVALID, 1'b0);
            else begin
               r_exp_t e;
               e = r_q.pop_front();
               check("rdata", RDATA, e.data);
               check("rresp", RRESP, e.resp);
            end
            r_seen++;
         end
         if (WR_PULSE) begin
            if (p_q.size() == 0) check("wr_pulse_unexpected", WR_PULSE, 1'b0);
            else check("wr_idx", WR_IDX, p_q.pop_front());
         end
      end
   end

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] resp, input int idx);
      bit aw_done = 1'b0;
      bit w_done  = 1'b0;
      bit aw_acc, w_acc;
      b_q.push_back(resp);
      if (resp == RESP_OKAY) p_q.push_back(3'(idx));
      AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1;
      for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
         @(negedge CLK);
         aw_acc = AWVALID && AWREADY;
         w_acc  = WVALID && WREADY;
         @(posedge CLK); #1;
         if (aw_acc) begin AWVALID = 1'b0; aw_done = 1'b1; end
         if (w_acc)  begin WVALID  = 1'b0; w_done  = 1'b1; end
      end
      if (!(aw_done && w_done)) check("write_accept_timeout", {aw_done, w_done}, 2'b11);
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
      bit done = 1'b0;
      bit acc;
      r_q.push_back('{data: d, resp: resp});
      ARADDR = a; ARVALID = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge CLK);
         acc = ARVALID && ARREADY;
         @(posedge CLK); #1;
         if (acc) begin ARVALID = 1'b0; done = 1'b1; end
      end
      if (!done) check("read_accept_timeout", done, 1'b1);
   endtask

   task automatic wait_b(input int n);
      for (int i = 0; i < 100 && b_seen < n; i++) @(posedge CLK);
      #1;
      if (b_seen < n) check("b_timeout", b_seen, n);
   endtask

   task automatic wait_r(input int n);
      for (int i = 0; i < 100 && r_seen < n; i++) @(posedge CLK);
      #1;
      if (r_seen < n) check("r_timeout", r_seen, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
      BREADY = 1'b1; RREADY = 1'b1;
      AWADDR = '0; WDATA = '0; ARADDR = '0;
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;

      @(negedge CLK);
      check("rst_regs", REG_OUT, '0);
      check("rst_flags", {BVALID, RVALID, WR_PULSE, AWREADY, WREADY, ARREADY}, 6'b000111);
      check("rst_rdata", RDATA, 32'h0);
      @(posedge CLK); #1;

      // 1: AW and W together; BVALID two cycles after the handshake
      axi_write(32'h04, 32'hA5A5_0001, RESP_OKAY, 1);
      @(negedge CLK);
      check("t1_bvalid_t1", BVALID, 1'b0);
      @(negedge CLK);
      check("t1_bvalid_t2", BVALID, 1'b1);
      check("t1_wr_pulse", WR_PULSE, 1'b1);
      check("t1_reg1", REG_OUT[63:32], 32'hA5A5_0001);
      wait_b(1);

      // 2: W first, AW three cycles later
      b_q.push_back(RESP_OKAY); p_q.push_back(3'd2);
      WDATA = 32'h1234; WVALID = 1'b1;
      @(negedge CLK); check("t2_wready_idle", WREADY, 1'b1);
      @(posedge CLK); #1 WVALID = 1'b0;
      @(negedge CLK); check("t2_wready_t1", WREADY, 1'b0);
      @(posedge CLK); #1;
      @(negedge CLK); check("t2_wready_t2", WREADY, 1'b0);
      @(posedge CLK); #1 AWADDR = 32'h08; AWVALID = 1'b1;
      @(negedge CLK); check("t2_wready_t3", WREADY, 1'b0); check("t2_awready_t3", AWREADY, 1'b1);
      @(posedge CLK); #1 AWVALID = 1'b0;
      @(negedge CLK); check("t2_wready_t4", WREADY, 1'b0);
      wait_b(2);
      axi_read(32'h08, 32'h1234, RESP_OKAY);
      wait_r(1);
      axi_read(32'h04, 32'hA5A5_0001, RESP_OKAY);
      wait_r(2);

      // 3: out-of-range write and reads
      snapshot = REG_OUT;
      axi_write(32'h40, 32'hFFFF_FFFF, RESP_SLVERR, 0);
      wait_b(3);
      check("t3_regs_unchanged", REG_OUT, snapshot);
      axi_read(32'h40, 32'h0, RESP_SLVERR);
      wait_r(3);
      axi_read(32'h1000_0004, 32'h0, RESP_SLVERR);
      wait_r(4);

      // 4: B response held off by BREADY
      BREADY = 1'b0;
      axi_write(32'h10, 32'h55, RESP_OKAY, 4);
      for (int i = 0; i < 10 && !BVALID; i++) @(negedge CLK);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("t4_hold", {BVALID, BRESP, AWREADY, WREADY}, {1'b1, 2'b00, 1'b0, 1'b0});
      end
      @(posedge CLK); #1 BREADY = 1'b1;
      wait_b(4);
      axi_write(32'h14, 32'h66, RESP_OKAY, 5);
      wait_b(5);
      check("t4_reg4", REG_OUT[159:128], 32'h55);
      check("t4_reg5", REG_OUT[191:160], 32'h66);

      // 5: read in the commit cycle of a write to the same register sees the old value
      axi_write(32'h0C, 32'h11, RESP_OKAY, 3);
      wait_b(6);
      axi_write(32'h0C, 32'h22, RESP_OKAY, 3);
      r_q.push_back('{data: 32'h11, resp: RESP_OKAY});
      ARADDR = 32'h0C; ARVALID = 1'b1;
      @(negedge CLK); check("t5_arready", ARREADY, 1'b1);
      @(posedge CLK); #1 ARVALID = 1'b0;
      wait_r(5);
      wait_b(7);
      axi_read(32'h0C, 32'h22, RESP_OKAY);
      wait_r(6);

      // Top register, byte-offset bits ignored
      axi_write(32'h1C, 32'hDEAD_BEEF, RESP_OKAY, 7);
      wait_b(8);
      axi_read(32'h1F, 32'hDEAD_BEEF, RESP_OKAY);
      wait_r(7);

      // 6: reset with an address held and a read response pending
      RREADY = 1'b0;
      ARADDR = 32'h04; ARVALID = 1'b1;
      @(posedge CLK); #1 ARVALID = 1'b0;
      AWADDR = 32'h00; AWVALID = 1'b1;
      @(posedge CLK); #1 AWVALID = 1'b0;
      @(negedge CLK);
      check("t6_pre_rvalid", RVALID, 1'b1);
      check("t6_pre_awready", AWREADY, 1'b0);
      @(posedge CLK); #1 RESET = 1'b1;
      @(posedge CLK); #1 RESET = 1'b0;
      @(negedge CLK);
      check("t6_regs", REG_OUT, '0);
      check("t6_flags", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
      check("t6_rdata", RDATA, 32'h0);
      RREADY = 1'b1;
      @(posedge CLK); #1;
      axi_write(32'h00, 32'h77, RESP_OKAY, 0);
      wait_b(9);
      check("t6_reg0_after", REG_OUT[31:0], 32'h77);

      repeat (3) @(posedge CLK);
      check("b_queue_empty", b_q.size(), 0);
      check("r_queue_empty", r_q.size(), 0);
      check("pulse_queue_empty", p_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
